// File: rtl/noise_frame_sequencer_if.sv
// Pixel-in / block-out bus between the pixel source, the sequencer and the noise datapath.
// master = pixel source + datapath result side, slave = sequencer.
// Pure wiring container; no storage and no latency of its own.
interface noise_frame_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  // Upstream pixel stream and per-frame configuration
  logic [31:0]             cfg_blocks_per_frame;
  logic [DATA_WIDTH-1:0]   pix_in;
  logic                    pix_valid;
  logic                    pix_sof;
  logic                    pix_ready;

  // Framed stream towards the noise-estimation datapath
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    data_valid;
  logic                    start_data;
  logic                    end_data;
  logic                    start_of_frame;
  logic                    end_of_frame;
  logic [31:0]             blocks_per_frame;

  // Result return path and status
  logic [2*DATA_WIDTH-1:0] estimated_noise;
  logic                    estimated_noise_ready;
  logic [2*DATA_WIDTH-1:0] noise_out;
  logic                    noise_valid;
  logic                    busy;
  logic                    sof_error;
  logic                    cfg_error;

  modport master (
    output cfg_blocks_per_frame, pix_in, pix_valid, pix_sof,
    output estimated_noise, estimated_noise_ready,
    input  pix_ready, data_out, data_valid, start_data, end_data,
    input  start_of_frame, end_of_frame, blocks_per_frame,
    input  noise_out, noise_valid, busy, sof_error, cfg_error
  );

  modport slave (
    input  cfg_blocks_per_frame, pix_in, pix_valid, pix_sof,
    input  estimated_noise, estimated_noise_ready,
    output pix_ready, data_out, data_valid, start_data, end_data,
    output start_of_frame, end_of_frame, blocks_per_frame,
    output noise_out, noise_valid, busy, sof_error, cfg_error
  );
endinterface

// File: rtl/noise_frame_sequencer.sv
// Slices a pixel stream into TOTAL_SAMPLES-sample blocks with frame/block framing pulses, then waits for the noise result.
// Latency: 1 cycle from accepting edge to data_out/flags; result captured 1 cycle after estimated_noise_ready.
// Backpressure: pix_ready is registered and drops right after the frame's last sample until the result returns.
module noise_frame_sequencer #(
  parameter int DATA_WIDTH    = 8,
  parameter int TOTAL_SAMPLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  noise_frame_sequencer_if.slave bus
);

  // Sample counter width; TOTAL_SAMPLES is a power of two so the counter wraps naturally.
  localparam int            CW       = (TOTAL_SAMPLES > 1) ? $clog2(TOTAL_SAMPLES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    STREAM      = 2'd1,
    WAIT_RESULT = 2'd2
  } state_e;

  state_e                  state_q;
  logic [CW-1:0]           sample_cnt_q;
  logic [31:0]             block_cnt_q;
  logic [31:0]             bpf_q;

  logic                    pix_ready_q;
  logic                    busy_q;
  logic [DATA_WIDTH-1:0]   data_out_q;
  logic                    data_valid_q;
  logic                    start_data_q;
  logic                    end_data_q;
  logic                    sof_q;
  logic                    eof_q;
  logic [2*DATA_WIDTH-1:0] noise_out_q;
  logic                    noise_valid_q;
  logic                    sof_error_q;
  logic                    cfg_error_q;

  // Next-count values and the decode used by the FSM.
  logic [CW-1:0] sample_cnt_d;
  logic [31:0]   block_cnt_d;
  logic          accept;
  logic          cfg_zero;
  logic          last_sample;
  logic          last_block;
  logic          first_sample;

  assign sample_cnt_d = sample_cnt_q + CW'(1);
  assign block_cnt_d  = block_cnt_q + 32'd1;
  assign accept       = bus.pix_valid && pix_ready_q;
  assign cfg_zero     = (bus.cfg_blocks_per_frame == 32'd0);
  assign last_sample  = (sample_cnt_q == LAST_IDX);
  assign first_sample = (sample_cnt_q == '0);
  // bpf_q is never 0 while streaming, so the subtraction cannot wrap there.
  assign last_block   = (block_cnt_q == (bpf_q - 32'd1));

  // Frame FSM: counters, framing flags, result capture and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sample_cnt_q  <= '0;
      block_cnt_q   <= '0;
      bpf_q         <= '0;
      pix_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      start_data_q  <= 1'b0;
      end_data_q    <= 1'b0;
      sof_q         <= 1'b0;
      eof_q         <= 1'b0;
      noise_out_q   <= '0;
      noise_valid_q <= 1'b0;
      sof_error_q   <= 1'b0;
      cfg_error_q   <= 1'b0;
    end else begin
      // Pulses default low; pix_ready is only withheld while a result is outstanding.
      data_valid_q  <= 1'b0;
      start_data_q  <= 1'b0;
      end_data_q    <= 1'b0;
      sof_q         <= 1'b0;
      eof_q         <= 1'b0;
      noise_valid_q <= 1'b0;
      sof_error_q   <= 1'b0;
      cfg_error_q   <= 1'b0;
      pix_ready_q   <= 1'b1;

      case (state_q)
        IDLE: begin
          // Non-SOF pixels are swallowed here until a frame start arrives.
          if (accept && bus.pix_sof) begin
            if (cfg_zero) begin
              cfg_error_q <= 1'b1;
            end else begin
              bpf_q        <= bus.cfg_blocks_per_frame;
              sample_cnt_q <= CW'(1);
              block_cnt_q  <= '0;
              data_out_q   <= bus.pix_in;
              data_valid_q <= 1'b1;
              start_data_q <= 1'b1;
              sof_q        <= 1'b1;
              busy_q       <= 1'b1;
              state_q      <= STREAM;
            end
          end
        end

        STREAM: begin
          if (accept) begin
            if (bus.pix_sof) begin
              // A new SOF abandons the running frame; no end flags for it.
              sof_error_q <= 1'b1;
              if (cfg_zero) begin
                cfg_error_q <= 1'b1;
                busy_q      <= 1'b0;
                state_q     <= IDLE;
              end else begin
                bpf_q        <= bus.cfg_blocks_per_frame;
                sample_cnt_q <= CW'(1);
                block_cnt_q  <= '0;
                data_out_q   <= bus.pix_in;
                data_valid_q <= 1'b1;
                start_data_q <= 1'b1;
                sof_q        <= 1'b1;
              end
            end else begin
              data_out_q   <= bus.pix_in;
              data_valid_q <= 1'b1;
              start_data_q <= first_sample;
              end_data_q   <= last_sample;
              sof_q        <= first_sample && (block_cnt_q == 32'd0);
              eof_q        <= last_sample && last_block;
              sample_cnt_q <= sample_cnt_d;
              if (last_sample) begin
                block_cnt_q <= block_cnt_d;
              end
              // Frame complete: stop accepting until the datapath answers.
              if (last_sample && last_block) begin
                pix_ready_q <= 1'b0;
                state_q     <= WAIT_RESULT;
              end
            end
          end
        end

        WAIT_RESULT: begin
          if (bus.estimated_noise_ready) begin
            noise_out_q   <= bus.estimated_noise;
            noise_valid_q <= 1'b1;
            busy_q        <= 1'b0;
            sample_cnt_q  <= '0;
            block_cnt_q   <= '0;
            state_q       <= IDLE;
          end else begin
            pix_ready_q <= 1'b0;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.pix_ready        = pix_ready_q;
  assign bus.busy             = busy_q;
  assign bus.data_out         = data_out_q;
  assign bus.data_valid       = data_valid_q;
  assign bus.start_data       = start_data_q;
  assign bus.end_data         = end_data_q;
  assign bus.start_of_frame   = sof_q;
  assign bus.end_of_frame     = eof_q;
  assign bus.blocks_per_frame = bpf_q;
  assign bus.noise_out        = noise_out_q;
  assign bus.noise_valid      = noise_valid_q;
  assign bus.sof_error        = sof_error_q;
  assign bus.cfg_error        = cfg_error_q;

endmodule

// File: tb/tb_noise_frame_sequencer.sv
// Bench for noise_frame_sequencer: directed scenarios then random traffic against a frame-position model.
// Latency: outputs compared one cycle after each driven edge, on the falling edge.
// Backpressure: pixel acceptance is predicted by the model and pix_ready is compared every cycle.
module tb_noise_frame_sequencer;
  localparam int DW = 8;
  localparam int TS = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  noise_frame_sequencer_if #(.DATA_WIDTH(DW)) bus();

  noise_frame_sequencer #(.DATA_WIDTH(DW), .TOTAL_SAMPLES(TS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: position within the frame, mode 0=idle 1=stream 2=waiting for result.
  int            m_mode;
  longint        m_pos;
  logic [31:0]   m_bpf;
  logic [15:0]   m_noise;
  logic [DW-1:0] m_dout;
  bit            m_fresh;
  bit e_dv, e_sd, e_ed, e_sof, e_eof, e_nv, e_sofe, e_cfge;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return !m_fresh && (m_mode != 2);
  endfunction

  task automatic clear_flags();
    e_dv = 0; e_sd = 0; e_ed = 0; e_sof = 0; e_eof = 0; e_nv = 0; e_sofe = 0; e_cfge = 0;
  endtask

  task automatic check_outputs();
    chk("data_valid",       bus.data_valid,       e_dv);
    chk("data_out",         bus.data_out,         m_dout);
    chk("start_data",       bus.start_data,       e_sd);
    chk("end_data",         bus.end_data,         e_ed);
    chk("start_of_frame",   bus.start_of_frame,   e_sof);
    chk("end_of_frame",     bus.end_of_frame,     e_eof);
    chk("blocks_per_frame", bus.blocks_per_frame, m_bpf);
    chk("noise_out",        bus.noise_out,        m_noise);
    chk("noise_valid",      bus.noise_valid,      e_nv);
    chk("busy",             bus.busy,             m_mode != 0);
    chk("sof_error",        bus.sof_error,        e_sofe);
    chk("cfg_error",        bus.cfg_error,        e_cfge);
  endtask

  // Forward one pixel at the current frame position.
  task automatic fwd(input logic [DW-1:0] p);
    e_dv   = 1;
    m_dout = p;
    e_sd   = (m_pos % TS) == 0;
    e_ed   = (m_pos % TS) == TS - 1;
    e_sof  = (m_pos == 0);
    e_eof  = (m_pos == longint'(m_bpf) * TS - 1);
    m_pos++;
    if (e_eof) m_mode = 2;
  endtask

  task automatic start_frame(input logic [31:0] cfg, input logic [DW-1:0] p);
    m_bpf  = cfg;
    m_pos  = 0;
    m_mode = 1;
    fwd(p);
  endtask

  // One clock: drive at the falling edge, predict, compare at the next falling edge.
  task automatic cycle(input bit v, input bit sof, input logic [DW-1:0] pix,
                       input logic [31:0] cfg, input bit nr, input logic [15:0] nz);
    bit acc;
    bus.pix_valid             = v;
    bus.pix_sof               = sof;
    bus.pix_in                = pix;
    bus.cfg_blocks_per_frame  = cfg;
    bus.estimated_noise_ready = nr;
    bus.estimated_noise       = nz;
    #1;
    chk("pix_ready", bus.pix_ready, exp_ready());
    acc = v && exp_ready();
    clear_flags();
    m_fresh = 0;
    case (m_mode)
      0: if (acc && sof) begin
           if (cfg != 0) start_frame(cfg, pix);
           else e_cfge = 1;
         end
      1: if (acc) begin
           if (sof) begin
             e_sofe = 1;
             if (cfg != 0) start_frame(cfg, pix);
             else begin e_cfge = 1; m_mode = 0; end
           end else begin
             fwd(pix);
           end
         end
      default: if (nr) begin
           m_noise = nz;
           e_nv    = 1;
           m_mode  = 0;
         end
    endcase
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 32'd2, 0, 16'h0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    bus.pix_valid = 0; bus.pix_sof = 0; bus.pix_in = '0;
    bus.cfg_blocks_per_frame = 32'd2;
    bus.estimated_noise_ready = 0; bus.estimated_noise = '0;
    #1;
    m_mode = 0; m_pos = 0; m_bpf = 0; m_noise = 0; m_dout = 0; m_fresh = 1;
    clear_flags();
    check_outputs();
    chk("pix_ready_rst", bus.pix_ready, 1'b0);
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1;
  endtask

  initial begin
    do_reset();

    // 1: two-block frame, result pulse coinciding with WAIT entry must be ignored.
    for (int i = 0; i < 8; i++)
      cycle(1, i == 0, 8'(8'h10 + i), 32'd2, i == 7, 16'hDEAD);
    // 2: result three cycles later.
    idle(3);
    cycle(0, 0, 8'h00, 32'd2, 1, 16'h0123);
    idle(2);

    // 3: non-SOF pixels dropped in IDLE, then SOF with zero config.
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'h30 + i), 32'd2, 0, 16'h0);
    cycle(1, 1, 8'h3F, 32'd0, 0, 16'h0);
    idle(2);

    // 4: mid-frame SOF restarts the frame.
    cycle(1, 1, 8'hA0, 32'd2, 0, 16'h0);
    cycle(1, 0, 8'hA1, 32'd2, 0, 16'h0);
    cycle(1, 0, 8'hA2, 32'd2, 0, 16'h0);
    for (int i = 0; i < 8; i++) cycle(1, i == 0, 8'(8'hB0 + i), 32'd2, 0, 16'h0);
    idle(1);
    cycle(0, 0, 8'h00, 32'd2, 1, 16'h4567);

    // 5: pix_valid toggling each cycle.
    for (int i = 0; i < 16; i++)
      cycle(i % 2 == 0, i == 0, (i % 2 == 0) ? 8'(8'h10 + i / 2) : 8'hEE, 32'd2, 0, 16'h0);
    idle(2);
    cycle(0, 0, 8'h00, 32'd2, 1, 16'h89AB);

    // 6: reset mid-block, then a fresh frame.
    cycle(1, 1, 8'hC0, 32'd2, 0, 16'h0);
    cycle(1, 0, 8'hC1, 32'd2, 0, 16'h0);
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1, i == 0, 8'(8'hD0 + i), 32'd2, 0, 16'h0);
    cycle(0, 0, 8'h00, 32'd2, 1, 16'h0F0F);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      bit v, sof, nr;
      logic [31:0] cfg;
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        v   = $urandom_range(0, 9) < 7;
        sof = (m_mode == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
        cfg = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 3));
        nr  = $urandom_range(0, 3) == 0;
        cycle(v, sof, 8'($urandom), cfg, nr, 16'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
